// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode, ALU and mux-select codes plus the decoded control bundle
package riscv_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [4:0] ALU_SLTU = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd10;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic [4:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I(+M) instruction decode to control bundle and immediate
module decode_comb
  import riscv_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [31:0] imm,
  output logic        uses_rs1,
  output logic        uses_rs2
);
  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [2:0] imm_src;
  logic       bad;
  ctrl_t      c;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  always_comb begin
    c = '0;
    imm_src = IMM_I;
    bad = 1'b0;
    case (op)
      OP_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src_a = SRC_A_ZERO;
        c.alu_src_b = SRC_B_IMM;
        imm_src = IMM_U;
      end
      OP_AUIPC: begin
        c.reg_write = 1'b1;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_IMM;
        imm_src = IMM_U;
      end
      OP_JAL: begin
        c.reg_write = 1'b1;
        c.jump = 1'b1;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_IMM;
        c.result_src = RES_PC4;
        imm_src = IMM_J;
      end
      OP_JALR: begin
        c.reg_write = 1'b1;
        c.jump = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        c.result_src = RES_PC4;
        bad = f3 != 3'b000;
      end
      OP_BRANCH: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
        imm_src = IMM_B;
        bad = f3[2:1] == 2'b01;
      end
      OP_LOAD: begin
        c.reg_write = 1'b1;
        c.mem_read = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        c.result_src = RES_MEM;
        bad = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        imm_src = IMM_S;
        bad = f3 > 3'b010;
      end
      OP_IMM: begin
        c.reg_write = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op = alu_base(f3, f3 == 3'b101 && f7[5]);
        bad = f3 == 3'b001 ? f7 != 7'b0 : f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000;
      end
      OP_REG: begin
        c.reg_write = 1'b1;
        c.alu_op = f7 == 7'b0000001 ? ALU_MUL + 5'(f3) : alu_base(f3, f7[5]);
        bad = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                || (f7 == 7'b0000001 && EN_M));
      end
      OP_FENCE: ;
      default: bad = 1'b1;
    endcase
    ctrl = c;
    ctrl.illegal = bad;
    if (bad) {ctrl.reg_write, ctrl.mem_read, ctrl.mem_write, ctrl.branch, ctrl.jump} = 5'b0;
  end
  assign imm = imm_src == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
             : imm_src == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
             : imm_src == IMM_U ? {instr[31:12], 12'b0}
             : imm_src == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
             : {{20{instr[31]}}, instr[31:20]};
  assign uses_rs1 = op == OP_JALR || op == OP_BRANCH || op == OP_LOAD || op == OP_STORE
                 || op == OP_IMM || op == OP_REG;
  assign uses_rs2 = op == OP_BRANCH || op == OP_STORE || op == OP_REG;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with ID/EX handshake, load-use bubbles, flush and stall count
module decode_stage
  import riscv_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter bit EN_M     = 1'b0,
  parameter bit LOAD_USE = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid_i,
  output logic             if_ready_o,
  input  logic [31:0]      if_instr_i,
  input  logic [PC_W-1:0]  if_pc_i,
  input  logic             flush_i,
  output logic             ex_valid_o,
  input  logic             ex_ready_i,
  output logic [PC_W-1:0]  ex_pc_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic [31:0]      ex_imm_o,
  output logic [2:0]       ex_funct3_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             ex_branch_o,
  output logic             ex_jump_o,
  output logic [4:0]       ex_alu_op_o,
  output logic [1:0]       ex_alu_src_a_o,
  output logic [1:0]       ex_alu_src_b_o,
  output logic [1:0]       ex_result_src_o,
  output logic             ex_illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  ctrl_t       dec;
  ctrl_t       ex_ctrl;
  logic [31:0] dec_imm;
  logic        use_rs1;
  logic        use_rs2;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        adv;
  logic        hazard;
  logic        load;
  decode_comb #(.EN_M(EN_M)) u_dec (
    .instr    (if_instr_i),
    .ctrl     (dec),
    .imm      (dec_imm),
    .uses_rs1 (use_rs1),
    .uses_rs2 (use_rs2)
  );
  assign rs1 = if_instr_i[19:15];
  assign rs2 = if_instr_i[24:20];
  assign adv = !ex_valid_o || ex_ready_i;
  assign hazard = LOAD_USE && ex_valid_o && ex_ctrl.mem_read && ex_rd_o != 5'd0
               && ((use_rs1 && rs1 == ex_rd_o) || (use_rs2 && rs2 == ex_rd_o));
  assign if_ready_o = flush_i || (adv && !hazard);
  assign load = !flush_i && !hazard && if_valid_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o <= 1'b0;
      ex_ctrl <= '0;
      ex_pc_o <= '0;
      ex_rs1_o <= '0;
      ex_rs2_o <= '0;
      ex_rd_o <= '0;
      ex_imm_o <= '0;
      ex_funct3_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (flush_i || adv) begin
        ex_valid_o <= load;
        ex_ctrl <= load ? dec : '0;
        ex_pc_o <= if_pc_i;
        ex_rs1_o <= rs1;
        ex_rs2_o <= rs2;
        ex_rd_o <= if_instr_i[11:7];
        ex_imm_o <= dec_imm;
        ex_funct3_o <= if_instr_i[14:12];
      end
      if (if_valid_i && hazard && !flush_i && !(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end
  assign ex_reg_write_o = ex_ctrl.reg_write;
  assign ex_mem_read_o = ex_ctrl.mem_read;
  assign ex_mem_write_o = ex_ctrl.mem_write;
  assign ex_branch_o = ex_ctrl.branch;
  assign ex_jump_o = ex_ctrl.jump;
  assign ex_illegal_o = ex_ctrl.illegal;
  assign ex_alu_op_o = ex_ctrl.alu_op;
  assign ex_alu_src_a_o = ex_ctrl.alu_src_a;
  assign ex_alu_src_b_o = ex_ctrl.alu_src_b;
  assign ex_result_src_o = ex_ctrl.result_src;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: two configurations (M+load-use, neither) checked against a behavioural model
module tb_decode_stage;
  localparam int BASE_ALU [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
  localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic flush = 1'b0;
  logic ex_ready = 1'b0;
  logic if_ready [2];
  logic ex_valid [2];
  logic [31:0] ex_pc [2];
  logic [4:0] ex_rs1 [2];
  logic [4:0] ex_rs2 [2];
  logic [4:0] ex_rd [2];
  logic [31:0] ex_imm [2];
  logic [2:0] ex_f3 [2];
  logic ex_rw [2];
  logic ex_mr [2];
  logic ex_mw [2];
  logic ex_br [2];
  logic ex_jp [2];
  logic [4:0] ex_alu [2];
  logic [1:0] ex_sa [2];
  logic [1:0] ex_sb [2];
  logic [1:0] ex_rs [2];
  logic ex_ill [2];
  logic [15:0] dut_stall [2];
  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct packed {
    logic ok, u1, u2, rw, mr, mw, br, jp, ichk;
    logic [4:0] alu;
    logic [1:0] sa, sb, rs;
    logic [31:0] imm;
  } dec_t;
  typedef struct packed {
    logic v, rw, mr, mw, br, jp, ill, ok, ichk;
    logic [31:0] pc, imm;
    logic [4:0] rs1, rs2, rd, alu;
    logic [2:0] f3;
    logic [1:0] sa, sb, rs;
  } mst_t;
  mst_t m [2];
  logic [15:0] stall_m [2];
  always #5 clk = ~clk;
  decode_stage #(.PC_W(32), .EN_M(1'b1), .LOAD_USE(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(if_ready[0]), .if_instr_i(if_instr),
    .if_pc_i(if_pc), .flush_i(flush), .ex_valid_o(ex_valid[0]), .ex_ready_i(ex_ready),
    .ex_pc_o(ex_pc[0]), .ex_rs1_o(ex_rs1[0]), .ex_rs2_o(ex_rs2[0]), .ex_rd_o(ex_rd[0]),
    .ex_imm_o(ex_imm[0]), .ex_funct3_o(ex_f3[0]), .ex_reg_write_o(ex_rw[0]), .ex_mem_read_o(ex_mr[0]),
    .ex_mem_write_o(ex_mw[0]), .ex_branch_o(ex_br[0]), .ex_jump_o(ex_jp[0]), .ex_alu_op_o(ex_alu[0]),
    .ex_alu_src_a_o(ex_sa[0]), .ex_alu_src_b_o(ex_sb[0]), .ex_result_src_o(ex_rs[0]),
    .ex_illegal_o(ex_ill[0]), .stall_cnt_o(dut_stall[0]));
  decode_stage #(.PC_W(32), .EN_M(1'b0), .LOAD_USE(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(if_ready[1]), .if_instr_i(if_instr),
    .if_pc_i(if_pc), .flush_i(flush), .ex_valid_o(ex_valid[1]), .ex_ready_i(ex_ready),
    .ex_pc_o(ex_pc[1]), .ex_rs1_o(ex_rs1[1]), .ex_rs2_o(ex_rs2[1]), .ex_rd_o(ex_rd[1]),
    .ex_imm_o(ex_imm[1]), .ex_funct3_o(ex_f3[1]), .ex_reg_write_o(ex_rw[1]), .ex_mem_read_o(ex_mr[1]),
    .ex_mem_write_o(ex_mw[1]), .ex_branch_o(ex_br[1]), .ex_jump_o(ex_jp[1]), .ex_alu_op_o(ex_alu[1]),
    .ex_alu_src_a_o(ex_sa[1]), .ex_alu_src_b_o(ex_sb[1]), .ex_result_src_o(ex_rs[1]),
    .ex_illegal_o(ex_ill[1]), .stall_cnt_o(dut_stall[1]));
  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s cfg%0d: got 0x%0h, expected 0x%0h", tag, k, obs, exp);
    end
  endtask
  function automatic dec_t exp_dec(input logic [31:0] i, input bit em);
    dec_t d;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [31:0] ii;
    f7 = i[31:25];
    f3 = i[14:12];
    ii = {{20{i[31]}}, i[31:20]};
    d = '0;
    d.ichk = 1'b1;
    case (i[6:0])
      7'h37: begin d.ok = 1; d.rw = 1; d.sa = 2; d.sb = 1; d.imm = {i[31:12], 12'h0}; end
      7'h17: begin d.ok = 1; d.rw = 1; d.sa = 1; d.sb = 1; d.imm = {i[31:12], 12'h0}; end
      7'h6f: begin
        d.ok = 1; d.rw = 1; d.jp = 1; d.sa = 1; d.sb = 1; d.rs = 2;
        d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'h67: begin d.ok = f3 == 0; d.u1 = 1; d.rw = 1; d.jp = 1; d.sb = 1; d.rs = 2; d.imm = ii; end
      7'h63: begin
        d.ok = !(f3 inside {3'd2, 3'd3}); d.u1 = 1; d.u2 = 1; d.br = 1; d.alu = 5'd1;
        d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h03: begin d.ok = !(f3 inside {3'd3, 3'd6, 3'd7}); d.u1 = 1; d.rw = 1; d.mr = 1; d.sb = 1; d.rs = 1; d.imm = ii; end
      7'h23: begin d.ok = f3 <= 2; d.u1 = 1; d.u2 = 1; d.mw = 1; d.sb = 1; d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
      7'h13: begin
        d.ok = f3 == 1 ? f7 == 0 : (f3 != 5 || f7 == 7'd0 || f7 == 7'd32);
        d.u1 = 1; d.rw = 1; d.sb = 1; d.imm = ii;
        d.alu = (f3 == 5 && f7 == 7'd32) ? 5'd9 : 5'(BASE_ALU[f3]);
      end
      7'h33: begin
        d.ok = f7 == 0 || (f7 == 7'd32 && (f3 == 0 || f3 == 5)) || (f7 == 7'd1 && em);
        d.u1 = 1; d.u2 = 1; d.rw = 1; d.ichk = 0;
        d.alu = f7 == 7'd1 ? 5'(10 + f3) : f7 == 7'd32 ? (f3 == 0 ? 5'd1 : 5'd9) : 5'(BASE_ALU[f3]);
      end
      7'h0f: begin d.ok = 1; d.ichk = 0; end
      default: d.ok = 0;
    endcase
    if (!d.ok) {d.rw, d.mr, d.mw, d.br, d.jp} = 5'b0;
    return d;
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [31:0] i;
    int sel;
    i = $urandom;
    sel = $urandom_range(0, 12);
    if (sel < 11) i[6:0] = OPS[sel];
    i[11:7] = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: i[31:25] = 7'd0;
      1: i[31:25] = 7'd32;
      2: i[31:25] = 7'd1;
      default: ;
    endcase
    return sel == 12 && i[0] ? 32'h0 : i;
  endfunction
  task automatic check_state(input int k);
    chk("ex_valid", k, ex_valid[k], m[k].v);
    chk("reg_write", k, ex_rw[k], m[k].rw);
    chk("mem_read", k, ex_mr[k], m[k].mr);
    chk("mem_write", k, ex_mw[k], m[k].mw);
    chk("branch", k, ex_br[k], m[k].br);
    chk("jump", k, ex_jp[k], m[k].jp);
    chk("illegal", k, ex_ill[k], m[k].ill);
    chk("stall_cnt", k, dut_stall[k], stall_m[k]);
    if (m[k].v) begin
      chk("pc", k, ex_pc[k], m[k].pc);
      chk("rs1", k, ex_rs1[k], m[k].rs1);
      chk("rs2", k, ex_rs2[k], m[k].rs2);
      chk("rd", k, ex_rd[k], m[k].rd);
      chk("funct3", k, ex_f3[k], m[k].f3);
    end
    if (m[k].v && m[k].ok) begin
      chk("alu_op", k, ex_alu[k], m[k].alu);
      chk("src_a", k, ex_sa[k], m[k].sa);
      chk("src_b", k, ex_sb[k], m[k].sb);
      chk("result_src", k, ex_rs[k], m[k].rs);
    end
    if (m[k].v && m[k].ok && m[k].ichk) chk("imm", k, ex_imm[k], m[k].imm);
  endtask
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    dec_t d;
    mst_t nx;
    logic adv;
    logic haz;
    if_valid = v;
    if_instr = ins;
    if_pc = $urandom;
    ex_ready = rdy;
    flush = fl;
    #2;
    for (int k = 0; k < 2; k++) begin
      d = exp_dec(ins, k == 0);
      adv = !m[k].v || rdy;
      haz = k == 0 && m[k].v && m[k].mr && m[k].rd != 0
            && ((d.u1 && ins[19:15] == m[k].rd) || (d.u2 && ins[24:20] == m[k].rd));
      chk("if_ready", k, if_ready[k], fl || (adv && !haz));
      if (v && haz && !fl && stall_m[k] != 16'hFFFF) stall_m[k]++;
      nx = '0;
      if (v) begin
        nx.v = 1; nx.rw = d.rw; nx.mr = d.mr; nx.mw = d.mw; nx.br = d.br; nx.jp = d.jp;
        nx.ill = !d.ok; nx.ok = d.ok; nx.ichk = d.ichk; nx.pc = if_pc; nx.imm = d.imm;
        nx.rs1 = ins[19:15]; nx.rs2 = ins[24:20]; nx.rd = ins[11:7]; nx.f3 = ins[14:12];
        nx.alu = d.alu; nx.sa = d.sa; nx.sb = d.sb; nx.rs = d.rs;
      end
      if (fl || (adv && haz)) m[k] = '0;
      else if (adv) m[k] = nx;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_state(k);
    n_vec++;
  endtask
  initial begin
    m[0] = '0; m[1] = '0;
    stall_m[0] = '0; stall_m[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_state(k);
      chk("rst_alu_op", k, ex_alu[k], 5'd0);
    end
    rst = 1'b0;
    step(1, 32'h002081B3, 1, 0);
    chk("add_alu_op", 0, ex_alu[0], 5'd0);
    chk("add_reg_write", 0, ex_rw[0], 1'b1);
    chk("add_rd", 0, ex_rd[0], 5'd3);
    step(1, 32'hFFC0A283, 1, 0);
    chk("lw_imm", 0, ex_imm[0], 32'hFFFFFFFC);
    step(1, 32'h00528333, 1, 0);
    chk("lu_bubble", 0, ex_valid[0], 1'b0);
    chk("lu_stall", 0, dut_stall[0], 16'd1);
    chk("nolu_valid", 1, ex_valid[1], 1'b1);
    chk("nolu_stall", 1, dut_stall[1], 16'd0);
    step(1, 32'h00528333, 1, 0);
    chk("lu_after", 0, ex_rd[0], 5'd6);
    repeat (3) step(1, 32'h002081B3, 0, 0);
    step(1, 32'h002081B3, 1, 0);
    step(1, 32'h00000013, 1, 1);
    chk("flush_valid", 0, ex_valid[0], 1'b0);
    step(1, 32'h022081B3, 1, 0);
    chk("mul_alu_op", 0, ex_alu[0], 5'd10);
    chk("nom_illegal", 1, ex_ill[1], 1'b1);
    chk("nom_reg_write", 1, ex_rw[1], 1'b0);
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 9) < 8, rnd_instr(), $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
    step(1, 32'h00000013, 1, 1);
    step(1, 32'h002081B3, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_rst_valid", k, ex_valid[k], 1'b0);
      chk("async_rst_stall", k, dut_stall[k], 16'd0);
      m[k] = '0;
      stall_m[k] = '0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 20; n++)
      step(1, rnd_instr(), $urandom_range(0, 1) == 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
